dmem_arbiter: RTL and testbench

Two-master arbiter that shares the single-port data memory (`dmem`) between the `rv_core` load/store port (master 0) and a second requester such as a debug/loader engine (master 1). Arbitration is per cycle, with optional bus locking for multi-beat sequences and a bounded lock duration. Memory-side signals are driven combinationally from the granted master. Read data is registered and returned one cycle later with a valid strobe. The block sits between the masters and `dmem`, in front of its `MemWrite`/address/`WriteData`/`ReadData` pins.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/arb_pick.sv | 33 +++
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 tb/tb_dmem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and lock-length limits for the dmem_arbiter slice.
// Imported by dmem_arbiter and arb_pick.
package dmem_arb_pkg;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

  typedef logic arb_id_t;

  localparam int MAX_LOCK_MIN = 1;
  localparam int MAX_LOCK_MAX = 255;
  localparam int LOCK_CNT_W   = 8;

  // Keeps an out-of-range MAX_LOCK from wrapping the 8-bit lock counter.
  function automatic int clampLock(input int maxLock);
    if (maxLock < MAX_LOCK_MIN) return MAX_LOCK_MIN;
    if (maxLock > MAX_LOCK_MAX) return MAX_LOCK_MAX;
    return maxLock;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Two-input one-hot picker used while the arbiter is IDLE.
// Macro DMEM_ARB_RR_EN: ties go to the master that was not granted last; otherwise master 0 wins ties.
module arb_pick
  import dmem_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  arb_id_t    lastGnt,
  output logic [1:0] gnt
);

  logic tieTo1;

`ifdef DMEM_ARB_RR_EN
  assign tieTo1 = (lastGnt == 1'b0);
`else
  logic unusedLastGnt;
  assign unusedLastGnt = lastGnt;
  assign tieTo1        = 1'b0;
`endif

  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) begin
      gnt = tieTo1 ? 2'b10 : 2'b01;
    end else if (req0) begin
      gnt = 2'b01;
    end else if (req1) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-port dmem: same-cycle grant, registered read return,
// optional bus lock bounded to MAX_LOCK cycles. Tie policy set by macro DMEM_ARB_RR_EN (see arb_pick).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_lock,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int                    LOCK_LEN  = clampLock(MAX_LOCK);
  localparam logic [LOCK_CNT_W-1:0] LOCK_LOAD = LOCK_CNT_W'(LOCK_LEN - 1);
  localparam logic [LOCK_CNT_W-1:0] CNT_ONE   = LOCK_CNT_W'(1);

  arb_state_t            state;
  logic [LOCK_CNT_W-1:0] lockCnt;
  arb_id_t               lastGnt;
  logic [1:0]            pickGnt;
  logic                  gnt0;
  logic                  gnt1;
  logic                  gntAny;
  logic                  gntWe;
  logic                  gntLock;
  logic                  ownReq;
  logic                  ownLock;

  arb_pick uPick (
    .req0    (m0_req),
    .req1    (m1_req),
    .lastGnt (lastGnt),
    .gnt     (pickGnt)
  );

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    {gnt1, gnt0} = pickGnt;
        OWN0:    gnt0 = m0_req;
        OWN1:    gnt1 = m1_req;
        default: ;
      endcase
    end
  end

  assign gntAny  = gnt0 | gnt1;
  assign gntWe   = gnt1 ? m1_we   : m0_we;
  assign gntLock = gnt1 ? m1_lock : m0_lock;
  assign ownReq  = (state == OWN1) ? m1_req  : m0_req;
  assign ownLock = (state == OWN1) ? m1_lock : m0_lock;

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign mem_we    = gntAny & gntWe;
  assign mem_addr  = gnt1 ? m1_addr  : m0_addr;
  assign mem_wdata = gnt1 ? m1_wdata : m0_wdata;

  // The opening IDLE grant is the first of MAX_LOCK owned cycles, so the owned
  // cycle that drains lockCnt to zero is the last one; MAX_LOCK=1 never enters OWNx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lockCnt   <= '0;
      lastGnt   <= 1'b1;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= gnt0 & ~m0_we;
      m1_rvalid <= gnt1 & ~m1_we;
      if (gnt0 && !m0_we) m0_rdata <= mem_rdata;
      if (gnt1 && !m1_we) m1_rdata <= mem_rdata;
      if (gntAny) lastGnt <= gnt1;
      case (state)
        IDLE: begin
          if (gntAny && gntLock && (LOCK_LEN > 1)) begin
            state   <= gnt1 ? OWN1 : OWN0;
            lockCnt <= LOCK_LOAD;
          end
        end
        OWN0, OWN1: begin
          if (!ownReq || !ownLock || (lockCnt == CNT_ONE)) begin
            state   <= IDLE;
            lockCnt <= '0;
          end else begin
            lockCnt <= lockCnt - CNT_ONE;
          end
        end
        default: begin
          state   <= IDLE;
          lockCnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter (MAX_LOCK=4): directed scenarios plus a randomized run
// against a transaction-level reference model. Honours DMEM_ARB_RR_EN like the design.
module tb_dmem_arbiter;

  localparam int ML = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 0, m0_we = 0, m0_lock = 0;
  logic        m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        forceRd = 1'b0;
  logic [31:0] forceVal = 32'h0;
  logic [31:0] dmem   [16] = '{default: 32'h0};
  logic [31:0] shadow [16] = '{default: 32'h0};

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DW(32), .AW(32), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Environment: the dmem itself, with an override for directed read data.
  assign mem_rdata = forceRd ? forceVal : dmem[mem_addr[5:2]];
  always @(posedge clk) if (mem_we) dmem[mem_addr[5:2]] <= mem_wdata;

  // ---------------- reference model ----------------
  int          owner;     // -1: nobody holds a lock
  int          held;      // consecutive grants so far under the current lock
  int          lastWin;
  int          expG;      // -1: no grant expected this cycle
  logic        expRv0, expRv1;
  logic [31:0] expRd0, expRd1;

  function automatic int grantOf(input logic rst, input int own, input int last,
                                 input logic r0, input logic r1);
    if (rst) return -1;
    if (own == 0) return r0 ? 0 : -1;
    if (own == 1) return r1 ? 1 : -1;
    if (r0 && r1) begin
`ifdef DMEM_ARB_RR_EN
      return (last == 0) ? 1 : 0;
`else
      return (last >= 0) ? 0 : 0;
`endif
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  always_comb expG = grantOf(reset, owner, lastWin, m0_req, m1_req);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      owner   <= -1;
      held    <= 0;
      lastWin <= 1;
      expRv0  <= 1'b0;
      expRv1  <= 1'b0;
      expRd0  <= 32'h0;
      expRd1  <= 32'h0;
    end else begin
      expRv0 <= (expG == 0) && !m0_we;
      expRv1 <= (expG == 1) && !m1_we;
      if (expG == 0 && !m0_we) expRd0 <= forceRd ? forceVal : shadow[m0_addr[5:2]];
      if (expG == 1 && !m1_we) expRd1 <= forceRd ? forceVal : shadow[m1_addr[5:2]];
      if (expG == 0 && m0_we) shadow[m0_addr[5:2]] <= m0_wdata;
      if (expG == 1 && m1_we) shadow[m1_addr[5:2]] <= m1_wdata;
      if (expG >= 0) lastWin <= expG;
      if (owner < 0) begin
        if (expG >= 0 && ((expG == 0) ? m0_lock : m1_lock) && ML > 1) begin
          owner <= expG;
          held  <= 1;
        end
      end else if (expG != owner || !((owner == 0) ? m0_lock : m1_lock) || held + 1 >= ML) begin
        owner <= -1;
        held  <= 0;
      end else begin
        held <= held + 1;
      end
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic l0, input logic r1, input logic w1, input logic [31:0] a1,
                       input logic [31:0] d1, input logic l1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0; m0_lock = l0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_lock = l1;
    #1;
  endtask

  task automatic idle_cycle;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle_cycle();
    reset = 1'b0;
    idle_cycle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'h10, 0, 1, (i != 1), 0, 32'h14, 0, 1);
      nChecks++;
      if ({m1_gnt, m0_gnt} !== 2'b00) begin
        nFails++; $display("FAIL reset_gnt: got %b required 00", {m1_gnt, m0_gnt});
      end
      nChecks++;
      if ({m1_rvalid, m0_rvalid} !== 2'b00) begin
        nFails++; $display("FAIL reset_rvalid: got %b required 00", {m1_rvalid, m0_rvalid});
      end
      nChecks++;
      if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
        nFails++; $display("FAIL reset_rdata: got %h/%h required 0/0", m0_rdata, m1_rdata);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    forceRd = 1'b1;
    forceVal = 32'hDEADBEEF;
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    $display("txn reset_read m0 addr=%h gnt=%b%b", m0_addr, m1_gnt, m0_gnt);
    nChecks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      nFails++; $display("FAIL first_read_gnt: got m0=%b m1=%b required m0=1 m1=0", m0_gnt, m1_gnt);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nChecks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin
      nFails++; $display("FAIL first_read_data: got rvalid=%b rdata=%h required 1 deadbeef", m0_rvalid, m0_rdata);
    end
    forceRd = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tie;
    int expWin [4];
`ifdef DMEM_ARB_RR_EN
    expWin = '{0, 1, 0, 1};
`else
    expWin = '{0, 0, 0, 0};
`endif
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'h4, 0, 0, 1, 0, 32'h8, 0, 0);
      $display("txn tie %0d gnt=%b%b", i, m1_gnt, m0_gnt);
      nChecks++;
      if (m0_gnt !== (expWin[i] == 0) || m1_gnt !== (expWin[i] == 1)) begin
        nFails++; $display("FAIL tie_%0d: got m0=%b m1=%b required winner %0d", i, m0_gnt, m1_gnt, expWin[i]);
      end
      @(negedge clk);
    end
    idle_cycle();
  endtask

  task automatic test_lock;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      // m1 opens alone, holds lock for three beats, unlocks on the fourth; m0 joins from beat two
      drive(c > 0, 0, 32'h4, 0, 0, 1, 0, 32'hC, 0, c < 3);
      $display("txn lock %0d gnt=%b%b", c, m1_gnt, m0_gnt);
      nChecks++;
      if (m1_gnt !== (c < 4) || m0_gnt !== (c == 4)) begin
        nFails++; $display("FAIL lock_%0d: got m0=%b m1=%b required m0=%b m1=%b", c, m0_gnt, m1_gnt, c == 4, c < 4);
      end
      @(negedge clk);
    end
    idle_cycle();
  endtask

  task automatic test_lock_timeout;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(c > 0, 0, 32'h4, 0, 0, 1, 0, 32'hC, 0, 1);
      $display("txn timeout %0d gnt=%b%b", c, m1_gnt, m0_gnt);
      nChecks++;
      if (m1_gnt !== (c < 4) || m0_gnt !== (c == 4)) begin
        nFails++; $display("FAIL timeout_%0d: got m0=%b m1=%b required m0=%b m1=%b", c, m0_gnt, m1_gnt, c == 4, c < 4);
      end
      @(negedge clk);
    end
    idle_cycle();
  endtask

  task automatic test_write;
    drive(1, 1, 32'h20, 32'h12345678, 0, 0, 0, 0, 0, 0);
    $display("txn write m0 addr=%h data=%h we=%b", mem_addr, mem_wdata, mem_we);
    nChecks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h12345678) begin
      nFails++; $display("FAIL write_bus: got we=%b addr=%h data=%h required 1 20 12345678", mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 0, 32'h20, 0, 0);
    $display("txn read m1 addr=%h gnt=%b", m1_addr, m1_gnt);
    nChecks++;
    if (m0_rvalid !== 1'b0) begin
      nFails++; $display("FAIL write_no_rvalid: got %b required 0", m0_rvalid);
    end
    nChecks++;
    if (m1_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h20) begin
      nFails++; $display("FAIL m1_read_bus: got gnt=%b we=%b addr=%h required 1 0 20", m1_gnt, mem_we, mem_addr);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nChecks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h12345678) begin
      nFails++; $display("FAIL m1_read_data: got rvalid=%b rdata=%h required 1 12345678", m1_rvalid, m1_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read;
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 0, 32'h8, 0, 1);
    nChecks++;
    if (m1_gnt !== 1'b1) begin
      nFails++; $display("FAIL midrst_open: got m1_gnt=%b required 1", m1_gnt);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 0, 32'h8, 0, 1);
    nChecks++;
    if (m1_gnt !== 1'b1 || m1_rvalid !== 1'b1) begin
      nFails++; $display("FAIL midrst_second: got gnt=%b rvalid=%b required 1 1", m1_gnt, m1_rvalid);
    end
    reset = 1'b1;
    #1;
    $display("txn reset asserted mid-lock gnt=%b%b rvalid=%b", m1_gnt, m0_gnt, m1_rvalid);
    nChecks++;
    if (m1_rvalid !== 1'b0 || {m1_gnt, m0_gnt} !== 2'b00) begin
      nFails++; $display("FAIL midrst_clear: got rvalid=%b gnt=%b%b required 0 00", m1_rvalid, m1_gnt, m0_gnt);
    end
    @(negedge clk);
    #1;
    nChecks++;
    if (m1_rvalid !== 1'b0) begin
      nFails++; $display("FAIL midrst_dropped: got rvalid=%b required 0", m1_rvalid);
    end
    reset = 1'b0;
    drive(1, 0, 32'h4, 0, 0, 1, 0, 32'h8, 0, 1);
    nChecks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      nFails++; $display("FAIL midrst_idle: got m0=%b m1=%b required m0=1 m1=0", m0_gnt, m1_gnt);
    end
    @(negedge clk);
    idle_cycle();
    idle_cycle();
  endtask

  task automatic test_random;
    logic [31:0] a0, a1;
    do_reset();
    for (int n = 0; n < 200; n++) begin
      a0 = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      a1 = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, a0, $urandom, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, a1, $urandom, $urandom_range(0, 1) == 1);
      $display("txn rnd %0d req=%b%b we=%b%b lock=%b%b gnt=%b%b", n, m1_req, m0_req, m1_we, m0_we,
               m1_lock, m0_lock, m1_gnt, m0_gnt);
      nChecks++;
      if (m0_gnt !== (expG == 0) || m1_gnt !== (expG == 1)) begin
        nFails++; $display("FAIL rnd_gnt %0d: got %b%b required winner %0d", n, m1_gnt, m0_gnt, expG);
      end
      nChecks++;
      if (mem_we !== ((expG == 0 && m0_we) || (expG == 1 && m1_we))) begin
        nFails++; $display("FAIL rnd_mem_we %0d: got %b", n, mem_we);
      end
      if (expG >= 0) begin
        nChecks++;
        if (mem_addr !== ((expG == 1) ? m1_addr : m0_addr) || mem_wdata !== ((expG == 1) ? m1_wdata : m0_wdata)) begin
          nFails++; $display("FAIL rnd_mem_bus %0d: got addr=%h data=%h for master %0d", n, mem_addr, mem_wdata, expG);
        end
      end
      nChecks++;
      if (m0_rvalid !== expRv0 || m1_rvalid !== expRv1) begin
        nFails++; $display("FAIL rnd_rvalid %0d: got %b%b required %b%b", n, m1_rvalid, m0_rvalid, expRv1, expRv0);
      end
      nChecks++;
      if (m0_rdata !== expRd0 || m1_rdata !== expRd1) begin
        nFails++; $display("FAIL rnd_rdata %0d: got %h/%h required %h/%h", n, m0_rdata, m1_rdata, expRd0, expRd1);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_tie();
    test_lock();
    test_lock_timeout();
    test_write();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
